// File: rtl/axi_lite_regs_slv.sv
// AXI-Lite register file responder: NumRegs byte-writable registers with
// independent one-deep AW/W buffers, registered B/R responses, SLVERR off-map.
package axi_lite_pkg;
   typedef struct packed {
      logic [31:0] addr;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_chan_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } resp_t;
endpackage

module axi_lite_regs_slv #(
   parameter int unsigned          NumRegs   = 4,
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter logic [DataWidth-1:0] ResetVal  = '0,
   parameter type                  axi_req_t  = axi_lite_pkg::req_t,
   parameter type                  axi_resp_t = axi_lite_pkg::resp_t
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  axi_req_t                           slv_req_i,
   output axi_resp_t                          slv_resp_o,
   output logic [NumRegs-1:0][DataWidth-1:0]  reg_q_o,
   output logic [NumRegs-1:0]                 reg_wr_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned OffWidth  = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = AddrWidth - OffWidth;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;

   logic                              aw_full, w_full, b_valid, r_valid;
   logic [IdxWidth-1:0]               aw_idx;
   logic [DataWidth-1:0]              w_data;
   logic [StrbWidth-1:0]              w_strb;
   logic [1:0]                        b_resp, r_resp;
   logic [DataWidth-1:0]              r_data;
   logic [NumRegs-1:0][DataWidth-1:0] reg_q;
   logic [NumRegs-1:0]                reg_wr;

   logic                 aw_hs, w_hs, ar_hs, commit;
   logic [IdxWidth-1:0]  ar_idx;
   logic [NumRegs-1:0]   wr_hit;
   logic                 wr_in_range, rd_in_range;
   logic [DataWidth-1:0] rd_data;

   // Byte-offset bits select a lane, not a register, so they are dropped.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{slv_req_i.aw.addr[OffWidth-1:0], slv_req_i.ar.addr[OffWidth-1:0]};

   assign ar_idx = slv_req_i.ar.addr[AddrWidth-1:OffWidth];
   assign aw_hs  = slv_req_i.aw_valid && !aw_full;
   assign w_hs   = slv_req_i.w_valid && !w_full;
   assign ar_hs  = slv_req_i.ar_valid && !r_valid;
   assign commit = aw_full && w_full && !b_valid;

   // NOTE: every variable gets a default before the loops so no latch is inferred.
   always_comb begin
      wr_hit      = '0;
      wr_in_range = 1'b0;
      rd_data     = '0;
      rd_in_range = 1'b0;
      for (int i = 0; i < int'(NumRegs); i++) begin
         if (aw_idx == IdxWidth'(i)) begin
            wr_hit[i]   = 1'b1;
            wr_in_range = 1'b1;
         end
         if (ar_idx == IdxWidth'(i)) begin
            rd_data     = reg_q[i];
            rd_in_range = 1'b1;
         end
      end
   end

   // NOTE: payload buffers are qualified by their full/valid flags, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (aw_hs) aw_idx <= slv_req_i.aw.addr[AddrWidth-1:OffWidth];
      if (w_hs) begin
         w_data <= slv_req_i.w.data;
         w_strb <= slv_req_i.w.strb;
      end
   end

   // NOTE: all state below uses non-blocking assignments; reads of reg_q see the pre-edge value.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         b_valid <= 1'b0;
         b_resp  <= RespOkay;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_resp  <= RespOkay;
         reg_q   <= {NumRegs{ResetVal}};
         reg_wr  <= '0;
      end else begin
         reg_wr <= '0;
         if (aw_hs) aw_full <= 1'b1;
         if (w_hs)  w_full  <= 1'b1;
         if (b_valid && slv_req_i.b_ready) b_valid <= 1'b0;

         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            b_valid <= 1'b1;
            b_resp  <= wr_in_range ? RespOkay : RespSlverr;
            for (int i = 0; i < int'(NumRegs); i++) begin
               if (wr_hit[i]) begin
                  reg_wr[i] <= 1'b1;
                  for (int b = 0; b < int'(StrbWidth); b++) begin
                     if (w_strb[b]) reg_q[i][8*b +: 8] <= w_data[8*b +: 8];
                  end
               end
            end
         end

         if (r_valid && slv_req_i.r_ready) r_valid <= 1'b0;
         // ar_hs needs !r_valid, so capture never collides with the clear above.
         if (ar_hs) begin
            r_valid <= 1'b1;
            r_data  <= rd_data;
            r_resp  <= rd_in_range ? RespOkay : RespSlverr;
         end
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = !aw_full;
      slv_resp_o.w_ready  = !w_full;
      slv_resp_o.b_valid  = b_valid;
      slv_resp_o.b.resp   = b_resp;
      slv_resp_o.ar_ready = !r_valid;
      slv_resp_o.r_valid  = r_valid;
      slv_resp_o.r.data   = r_data;
      slv_resp_o.r.resp   = r_resp;
   end

   assign reg_q_o  = reg_q;
   assign reg_wr_o = reg_wr;

endmodule
